// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter for the instruction and data request lines of a single-cycle datapath.
// One access is outstanding at a time and data requests win. Hits are registered pulses. Error flags and counters are kept here too.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        timeout_err,
  output logic        ram_err,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  // state | meaning
  // IDLE  | sample requests, data before fetch
  // IWAIT | fetch strobed on RAM, waiting for ACCESS
  // DWAIT | load/store strobed on RAM, waiting for ACCESS
  // IDONE | ihit pulse
  // DDONE | dhit pulse
  typedef enum logic [2:0] {IDLE, IWAIT, DWAIT, IDONE, DDONE} state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic [31:0] icnt_q, icnt_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic        terr_q, terr_d;
  logic        rerr_q, rerr_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      wcnt_q  <= '0;
      iload_q <= '0;
      dload_q <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
      terr_q  <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      wcnt_q  <= wcnt_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
      terr_q  <= terr_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    wcnt_d  = wcnt_q;
    iload_d = iload_q;
    dload_d = dload_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
    terr_d  = terr_q;
    rerr_d  = rerr_q;
    case (state_q)
      IDLE: begin
        if (dmemREN || dmemWEN) begin
          state_d = DWAIT;
          addr_d  = dmemaddr;
          store_d = dmemstore;
          wr_d    = dmemWEN;
          wcnt_d  = '0;
        end else if (imemREN && !halt) begin
          state_d = IWAIT;
          addr_d  = imemaddr;
          store_d = dmemstore;
          wr_d    = 1'b0;
          wcnt_d  = '0;
        end
      end
      IWAIT, DWAIT: begin
        if (ramstate == RS_ACCESS) begin
          // Counters advance on the same edge as the capture so they are current during the hit.
          if (state_q == IWAIT) begin
            state_d = IDONE;
            iload_d = ramload;
            icnt_d  = (icnt_q == '1) ? icnt_q : icnt_q + 32'd1;
          end else begin
            state_d = DDONE;
            if (!wr_q) dload_d = ramload;
            dcnt_d  = (dcnt_q == '1) ? dcnt_q : dcnt_q + 32'd1;
          end
        end else if (ramstate == RS_ERROR) begin
          rerr_d  = 1'b1;
          state_d = IDLE;
        end else if (wcnt_q == WAIT_LAST) begin
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      IDONE, DDONE: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  assign ramREN      = (state_q == IWAIT) || ((state_q == DWAIT) && !wr_q);
  assign ramWEN      = (state_q == DWAIT) && wr_q;
  assign ramaddr     = addr_q;
  assign ramstore    = store_q;
  assign ihit        = (state_q == IDONE);
  assign dhit        = (state_q == DDONE);
  assign imemload    = iload_q;
  assign dmemload    = dload_q;
  assign icount      = icnt_q;
  assign dcount      = dcnt_q;
  assign timeout_err = terr_q;
  assign ram_err     = rerr_q;

endmodule
